// File: rtl/array_ofm_drain.sv
// Deskews per-column systolic-array ofm outputs into aligned rows and buffers them in a row FIFO.
// Latency: WIDTH-1 cycles deskew, plus one cycle FIFO write; the row is visible WIDTH cycles after column 0 strobes.
// Backpressure: out_rdy stalls the FIFO only; the array cannot stall, so full pushes drop the row and set err_ovf.
// Optional OFM_RELU_EN: clamps negative lanes to zero at FIFO write.
module array_ofm_drain #(
    parameter int WIDTH    = 16,
    parameter int OWIDTH   = 24,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WIDTH-1:0][OWIDTH-1:0]   ofm,
    input  logic [WIDTH-1:0]               ofm_vld,
    input  logic                           clr_err,
    output logic [WIDTH-1:0][OWIDTH-1:0]   out_row,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic                           afull,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           err_ovf,
    output logic                           err_skew
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [WIDTH-1:0][OWIDTH-1:0] row_t;

    // Deskewed (aligned) valid and data vectors.
    logic [WIDTH-1:0] dv;
    row_t             dd;

    for (genvar w = 0; w < WIDTH; w++) begin : g_col
        if (w == WIDTH - 1) begin : g_pass
            // The last column arrives last, so it needs no delay.
            assign dv[w] = ofm_vld[w];
            assign dd[w] = ofm[w];
        end else begin : g_dly
            localparam int S = WIDTH - 1 - w;
            logic [S-1:0]             v_sr;
            logic [S-1:0][OWIDTH-1:0] d_sr;

            // Delay line: column w is held back WIDTH-1-w cycles to meet the last column.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_sr <= '0;
                    d_sr <= '0;
                end else begin
                    v_sr[0] <= ofm_vld[w];
                    d_sr[0] <= ofm[w];
                    for (int i = 1; i < S; i++) begin
                        v_sr[i] <= v_sr[i-1];
                        d_sr[i] <= d_sr[i-1];
                    end
                end
            end

            assign dv[w] = v_sr[S-1];
            assign dd[w] = d_sr[S-1];
        end
    end

    // FIFO state.
    row_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    row_t          wdat;
    logic          full;
    logic          pop;
    logic          push;
    logic          ovf_evt;
    logic          skew_evt;

    assign full     = (count == CW'(DEPTH));
    assign out_vld  = (count != '0);
    assign out_row  = out_vld ? mem[rd_ptr] : '0;
    assign pop      = out_vld && out_rdy;
    // Column 0 decides whether a row exists; a pop in the same cycle frees a slot for it.
    assign push     = dv[0] && (!full || pop);
    assign ovf_evt  = dv[0] && full && !pop;
    // Any partial valid vector means some column drifted off its expected skew.
    assign skew_evt = (|dv) && !(&dv);
    assign afull    = (DEPTH - int'(count)) <= AFULL_TH;

    // Lane masking and optional clamp applied to the row being written.
    always_comb begin
        wdat = '0;
        for (int w = 0; w < WIDTH; w++) begin
            if (dv[w]) begin
`ifdef OFM_RELU_EN
                wdat[w] = dd[w][OWIDTH-1] ? '0 : dd[w];
`else
                wdat[w] = dd[w];
`endif
            end
        end
    end

    // Row storage; output gating makes its reset state irrelevant.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdat;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a fresh event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf  <= 1'b0;
            err_skew <= 1'b0;
        end else begin
            if (ovf_evt) begin
                err_ovf <= 1'b1;
            end else if (clr_err) begin
                err_ovf <= 1'b0;
            end
            if (skew_evt) begin
                err_skew <= 1'b1;
            end else if (clr_err) begin
                err_skew <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_array_ofm_drain.sv
// Bench for array_ofm_drain: directed scenarios plus random traffic against a row-level reference model.
// Expected rows go into a scoreboard queue; a negedge monitor pops and compares whenever a row is delivered.
// Honours OFM_RELU_EN in the model when the macro is defined for the build.
module tb_array_ofm_drain;

    localparam int W  = 4;
    localparam int OW = 24;
    localparam int D  = 4;
    localparam int TH = 1;
    localparam int CW = $clog2(D + 1);
    localparam int HN = 64;

    typedef logic [W-1:0][OW-1:0] row_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    row_t          ofm = '0;
    logic [W-1:0]  ofm_vld = '0;
    logic          clr_err = 1'b0;
    row_t          out_row;
    logic          out_vld;
    logic          out_rdy = 1'b0;
    logic          afull;
    logic [CW-1:0] count;
    logic          err_ovf;
    logic          err_skew;

    always #5 clk = ~clk;

    array_ofm_drain #(.WIDTH(W), .OWIDTH(OW), .DEPTH(D), .AFULL_TH(TH)) dut (
        .clk(clk), .rst_n(rst_n), .ofm(ofm), .ofm_vld(ofm_vld), .clr_err(clr_err),
        .out_row(out_row), .out_vld(out_vld), .out_rdy(out_rdy), .afull(afull),
        .count(count), .err_ovf(err_ovf), .err_skew(err_skew)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard of rows the DUT must deliver, in order.
    row_t sb[$];

    // Future per-cycle input schedule and history of applied inputs.
    logic [W-1:0] sch_v [HN];
    row_t         sch_d [HN];
    logic [W-1:0] hv    [HN];
    row_t         hd    [HN];

    int cyc;
    int mcnt;
    bit m_ovf;
    bit m_skew;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [OW-1:0] lane_f(input logic [OW-1:0] x);
`ifdef OFM_RELU_EN
        return x[OW-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    task automatic clear_model();
        for (int i = 0; i < HN; i++) begin
            sch_v[i] = '0;
            sch_d[i] = '0;
            hv[i]    = '0;
            hd[i]    = '0;
        end
        cyc    = 0;
        mcnt   = 0;
        m_ovf  = 1'b0;
        m_skew = 1'b0;
        sb.delete();
    endtask

    // Schedule a row whose column 0 strobes dly cycles from now; lane 'late' (if >=0) arrives one cycle late.
    task automatic add_row(input int dly, input row_t vals, input int late);
        for (int w = 0; w < W; w++) begin
            int c;
            c = cyc + dly + w + ((w == late) ? 1 : 0);
            sch_v[c % HN][w] = 1'b1;
            sch_d[c % HN][w] = vals[w];
        end
    endtask

    function automatic row_t rand_row();
        row_t r;
        for (int w = 0; w < W; w++) r[w] = OW'($urandom);
        return r;
    endfunction

    // Reference: a row exists when the strobes of cycle c-(W-1-w) line up; FIFO is a counted queue.
    task automatic model_edge(input bit rdy, input bit clr);
        logic [W-1:0] dv;
        row_t r;
        bit pop, push, ovfe, sk;
        dv = '0;
        r  = '0;
        for (int w = 0; w < W; w++) begin
            int c;
            c = cyc - (W - 1 - w);
            if (c >= 0) begin
                dv[w] = hv[c % HN][w];
                if (dv[w]) r[w] = lane_f(hd[c % HN][w]);
            end
        end
        pop  = (mcnt > 0) && rdy;
        ovfe = dv[0] && (mcnt == D) && !pop;
        sk   = (dv != '0) && (dv != '1);
        push = dv[0] && ((mcnt < D) || pop);
        if (push) sb.push_back(r);
        mcnt = mcnt + int'(push) - int'(pop);
        m_ovf  = ovfe ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_skew = sk   ? 1'b1 : (clr ? 1'b0 : m_skew);
    endtask

    task automatic step(input bit rdy, input bit clr);
        int s;
        s = cyc % HN;
        ofm_vld = sch_v[s];
        ofm     = sch_d[s];
        out_rdy = rdy;
        clr_err = clr;
        hv[s]   = sch_v[s];
        hd[s]   = sch_d[s];
        sch_v[s] = '0;
        sch_d[s] = '0;
        @(posedge clk);
        #1;
        model_edge(rdy, clr);
        cyc++;
        chk("count",    64'(count),    64'(mcnt));
        chk("out_vld",  64'(out_vld),  64'(mcnt != 0));
        chk("afull",    64'(afull),    64'((D - mcnt) <= TH));
        chk("err_ovf",  64'(err_ovf),  64'(m_ovf));
        chk("err_skew", 64'(err_skew), 64'(m_skew));
    endtask

    task automatic do_reset();
        ofm_vld = '0;
        clr_err = 1'b0;
        rst_n   = 1'b0;
        #2;
        chk("rst_out_vld",  64'(out_vld),  64'd0);
        chk("rst_count",    64'(count),    64'd0);
        chk("rst_err_ovf",  64'(err_ovf),  64'd0);
        chk("rst_err_skew", 64'(err_skew), 64'd0);
        chk("rst_afull",    64'(afull),    64'd0);
        @(posedge clk);
        #1;
        clear_model();
        rst_n = 1'b1;
    endtask

    // Monitor: every delivered row must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_vld === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL row_unexpected: got %0h expected no row (cycle %0d)", out_row, cyc);
                end else begin
                    n_cmp++;
                    if (out_row !== sb[0]) begin
                        n_fail++;
                        $display("FAIL row_data: got %0h expected %0h (cycle %0d)", out_row, sb[0], cyc);
                    end
                    if (out_rdy) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        row_t v;
        bit   rdy_bias;
        clear_model();
        do_reset();

        // Aligned drain: column w strobes at cycle 10+w with 100+w.
        for (int w = 0; w < W; w++) v[w] = OW'(100 + w);
        add_row(10, v, -1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        chk("drain_empty", 64'(sb.size()), 64'd0);

        // Backpressure: five back-to-back rows with the consumer stalled.
        for (int k = 0; k < 5; k++) add_row(2 + k, rand_row(), -1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
        chk("bp_count", 64'(count),   64'd4);
        chk("bp_afull", 64'(afull),   64'd1);
        chk("bp_ovf",   64'(err_ovf), 64'd1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        chk("bp_drained", 64'(count), 64'd0);
        step(1'b1, 1'b1);
        chk("bp_clr", 64'(err_ovf), 64'd0);

        // Full FIFO with a pop in the same cycle as the fifth push.
        for (int k = 0; k < 5; k++) add_row(2 + k, rand_row(), -1);
        for (int i = 0; i < 12; i++) step(i == 9, 1'b0);
        chk("fullpp_count", 64'(count),   64'd4);
        chk("fullpp_ovf",   64'(err_ovf), 64'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);

        // Skew: lane 2 one cycle late.
        add_row(2, rand_row(), 2);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        chk("skew_set", 64'(err_skew), 64'd1);
        step(1'b1, 1'b1);
        chk("skew_clr", 64'(err_skew), 64'd0);

        // Reset with two rows buffered and one partially in the delay line.
        add_row(2, rand_row(), -1);
        add_row(3, rand_row(), -1);
        add_row(6, rand_row(), -1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        chk("pre_rst_count", 64'(count), 64'd2);
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);

        // Signed row {-5, 7, -1, 0} (lane 3 down to lane 0).
        v[3] = -24'sd5;
        v[2] = 24'sd7;
        v[1] = -24'sd1;
        v[0] = 24'sd0;
        add_row(2, v, -1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);

        // Random traffic with occasional skew, clears and stalls.
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) rdy_bias = ($urandom % 2) == 0;
            if ($urandom % 3 == 0)
                add_row(1, rand_row(), ($urandom % 10 == 0) ? int'($urandom % W) : -1);
            step(rdy_bias ? ($urandom % 5 != 0) : ($urandom % 3 == 0), $urandom % 16 == 0);
        end
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        chk("final_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/array_ofm_drain.md
Name: array_ofm_drain

Overview:
- Sits directly downstream of the systolic array and consumes its per-column ofm outputs.
- Array columns emit finished partial sums skewed in time: column w is one cycle later than column w-1. This block removes that skew so every column of a row lines up in the same cycle.
- Aligned rows are buffered in a small FIFO and delivered as a full-width row vector over a valid/ready handshake.
- The array cannot be stalled, so the block raises an almost-full warning for the controller and flags overflow or skew errors with sticky bits.

Parameters:
- WIDTH, 16, number of array columns (ofm lanes).
- OWIDTH, 24, signed width of each ofm word.
- DEPTH, 4, FIFO depth in rows; must be >= 2.
- AFULL_TH, 1, afull asserts when free entries <= AFULL_TH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- ofm  in  OWIDTH x [WIDTH-1:0]  signed per-column results from the array.
- ofm_vld  in  WIDTH  per-column strobe; column w is valid w cycles after column 0.
- clr_err  in  1  synchronous clear of the sticky error flags.
- out_row  out  OWIDTH x [WIDTH-1:0]  signed aligned row, head of the FIFO.
- out_vld  out  1  out_row holds valid data.
- out_rdy  in  1  consumer accepts the row.
- afull  out  1  FIFO almost full.
- count  out  $clog2(DEPTH+1)  number of occupied FIFO entries.
- err_ovf  out  1  sticky: a row was dropped because the FIFO was full.
- err_skew  out  1  sticky: delayed column valids disagreed.

Reset and clocking:
- One clock, clk.
- Reset is asynchronous and active-low on rst_n.

Behaviour:
- Reset: every delay-line register, FIFO pointer, count, err_ovf, err_skew, out_vld and afull is 0; out_row reads 0. Reset asserted mid-operation discards all in-flight and buffered rows immediately.
- Deskew:
  - Column w (data and valid) passes through WIDTH-1-w register stages. Column WIDTH-1 has 0 stages.
  - Delayed valid vector dv[w] is therefore aligned for a row whose column 0 strobed at cycle T; alignment occurs in cycle T+WIDTH-1.
- Row push:
  - A push occurs in any cycle where dv[0]=1.
  - If dv is not all-ones or not all-zeros in that cycle, err_skew is set. The row is still pushed; lanes with dv=0 are written as 0.
  - If dv[0]=0 but any dv[w]=1, err_skew is set and nothing is pushed.
- FIFO:
  - DEPTH entries with a circular write pointer and read pointer that wrap at DEPTH.
  - out_row/out_vld reflect the head entry (registered memory, combinational read of the head).
  - A pop occurs when out_vld && out_rdy.
  - A row pushed at the edge ending cycle T+WIDTH-1 into an empty FIFO gives out_vld=1 in cycle T+WIDTH.
- Boundary conditions:
  - Push and pop in the same cycle while full: pop first, push accepted, count unchanged, no error.
  - Push while full with no pop: row dropped, err_ovf set, FIFO contents untouched.
  - Pop while empty: impossible, because out_vld=0.
  - Push and pop in the same cycle while empty: push only; the row is visible the next cycle (no bypass).
- Flags:
  - count updates on every push/pop edge.
  - afull = (DEPTH - count) <= AFULL_TH, computed combinationally from count.
  - clr_err clears both sticky flags at the edge. If an error event coincides with clr_err, the error wins and the flag stays set.
  - out_row is stable while out_vld=1 and out_rdy=0.
- Arithmetic: no arithmetic on data other than the optional clamp; widths are preserved.

Optional Feature:
- Macro: OFM_RELU_EN.
- Defined: each lane is clamped at FIFO write; a negative value (MSB=1) is stored as 0, non-negative values pass unchanged. Latency is unchanged.
- Undefined: values pass through bit-exact.

Test Plan:
- Aligned drain (WIDTH=4, DEPTH=4):
  - Stimulus: column w strobes at cycle 10+w with ofm = 100+w; out_rdy held 1.
  - Required: out_vld=1 only in cycle 14, out_row = {103,102,101,100}, count returns to 0, no errors.
- Backpressure and overflow:
  - Stimulus: out_rdy=0, 5 rows injected one per cycle.
  - Required: count reaches 4; afull goes high at count=3; the 5th row is dropped; err_ovf=1. The first 4 rows then drain in order once out_rdy=1.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, out_rdy=1 in the cycle of a new push.
  - Required: count stays 4, err_ovf stays 0, FIFO order preserved.
- Skew error:
  - Stimulus: column 2 strobe arrives one cycle late.
  - Required: err_skew=1, lane 2 of the pushed row is 0. clr_err then clears the flag.
- Reset mid-operation:
  - Stimulus: rst_n pulsed low with 2 rows buffered and 1 row in flight.
  - Required: out_vld=0, count=0 and both flags 0 immediately; nothing emitted afterwards.
- OFM_RELU_EN:
  - Stimulus: row {-5, 7, -1, 0}.
  - Required: output {0, 7, 0, 0}. Without the macro the output is {-5, 7, -1, 0}.
